// File: rtl/reaction_round_if.sv
// Board/timer-side signal bundle for the reaction-round sequencer.
interface reaction_round_if;
    logic        BTNU;
    logic        BTND;
    logic [15:0] timer_bcd;
    logic        cnt_en;
    logic        cnt_clr;
    logic        led_go;
    logic [15:0] result_bcd;
    logic [15:0] best_bcd;
    logic [3:0]  round_idx;
    logic [2:0]  flag;

    modport master (
        output BTNU, BTND, timer_bcd,
        input  cnt_en, cnt_clr, led_go, result_bcd, best_bcd, round_idx, flag
    );

    modport slave (
        input  BTNU, BTND, timer_bcd,
        output cnt_en, cnt_clr, led_go, result_bcd, best_bcd, round_idx, flag
    );
endinterface

// File: rtl/reaction_round_ctrl.sv
// Multi-round reaction-tester sequencer: random hold-off, go cue, timer gating, best-time tracking.
// Optional button filter enabled by defining BTN_DEBOUNCE_EN.
module reaction_round_ctrl #(
    parameter int          ROUNDS      = 3,
    parameter int          MIN_DELAY   = 10000,
    parameter logic [15:0] RAND_MASK   = 16'h3FFF,
    parameter int          DLY_W       = 15,
    parameter int          DBNC_CYCLES = 100
) (
    input logic             clk_10k,
    input logic             reset,
    reaction_round_if.slave bus
);
    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StWait    = 3'd1;
    localparam logic [2:0] StArmed   = 3'd2;
    localparam logic [2:0] StDone    = 3'd3;
    localparam logic [2:0] StFoul    = 3'd4;
    localparam logic [2:0] StTimeout = 3'd5;
    localparam logic [2:0] StEnd     = 3'd6;

    localparam logic [15:0] Bcd9999 = 16'h9999;

    if (ROUNDS < 1 || ROUNDS > 15) begin : g_bad_rounds
        $error("ROUNDS must be 1..15");
    end
    if (DBNC_CYCLES < 1) begin : g_bad_dbnc
        $error("DBNC_CYCLES must be at least 1");
    end
    if (MIN_DELAY + int'(RAND_MASK) >= (1 << DLY_W)) begin : g_bad_dly
        $error("DLY_W too narrow for MIN_DELAY + RAND_MASK");
    end

    logic [1:0] btnu_sync_q, btnd_sync_q;
    logic       start_lvl, react_lvl;
    logic       start_prev_q, react_prev_q;
    logic       start_press, react_press;

    always_ff @(posedge clk_10k) begin
        if (reset) begin
            btnu_sync_q <= 2'b00;
            btnd_sync_q <= 2'b00;
        end else begin
            btnu_sync_q <= {btnu_sync_q[0], bus.BTNU};
            btnd_sync_q <= {btnd_sync_q[0], bus.BTND};
        end
    end

`ifdef BTN_DEBOUNCE_EN
    localparam int CW = $clog2(DBNC_CYCLES + 1);

    logic [CW-1:0] u_cnt_q, d_cnt_q;
    logic          u_filt_q, d_filt_q;

    // Filtered level flips only after the synchronized level differs for DBNC_CYCLES cycles.
    always_ff @(posedge clk_10k) begin
        if (reset) begin
            u_cnt_q  <= '0;
            d_cnt_q  <= '0;
            u_filt_q <= 1'b0;
            d_filt_q <= 1'b0;
        end else begin
            if (btnu_sync_q[1] == u_filt_q) begin
                u_cnt_q <= '0;
            end else if (u_cnt_q == CW'(DBNC_CYCLES - 1)) begin
                u_filt_q <= btnu_sync_q[1];
                u_cnt_q  <= '0;
            end else begin
                u_cnt_q <= u_cnt_q + CW'(1);
            end
            if (btnd_sync_q[1] == d_filt_q) begin
                d_cnt_q <= '0;
            end else if (d_cnt_q == CW'(DBNC_CYCLES - 1)) begin
                d_filt_q <= btnd_sync_q[1];
                d_cnt_q  <= '0;
            end else begin
                d_cnt_q <= d_cnt_q + CW'(1);
            end
        end
    end

    assign start_lvl = u_filt_q;
    assign react_lvl = d_filt_q;
`else
    assign start_lvl = btnu_sync_q[1];
    assign react_lvl = btnd_sync_q[1];
`endif

    assign start_press = start_lvl & ~start_prev_q;
    assign react_press = react_lvl & ~react_prev_q;

    logic [2:0]       state_q, state_d;
    logic [15:0]      lfsr_q;
    logic             lfsr_fb;
    logic [DLY_W-1:0] dly_q, dly_d, dly_load;
    logic [15:0]      result_q, result_d;
    logic [15:0]      best_q, best_d;
    logic [3:0]       round_q, round_d, round_inc;
    logic             clr_q, clr_d;
    logic             last_round;

    assign lfsr_fb    = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign dly_load   = DLY_W'(MIN_DELAY) + DLY_W'(lfsr_q & RAND_MASK);
    assign round_inc  = round_q + 4'd1;
    assign last_round = (round_inc == 4'(ROUNDS));

    always_comb begin
        state_d  = state_q;
        dly_d    = dly_q;
        result_d = result_q;
        best_d   = best_q;
        round_d  = round_q;
        clr_d    = 1'b0;
        case (state_q)
            StIdle, StDone, StFoul, StTimeout, StEnd: begin
                if (start_press) begin
                    state_d = StWait;
                    clr_d   = 1'b1;
                    dly_d   = dly_load;
                    if (state_q == StEnd) begin
                        round_d = 4'd0;
                        best_d  = Bcd9999;
                    end
                end
            end
            StWait: begin
                // React wins over an expiring hold-off in the same cycle.
                if (react_press) begin
                    result_d = Bcd9999;
                    round_d  = round_inc;
                    state_d  = last_round ? StEnd : StFoul;
                end else if (dly_q == '0) begin
                    state_d = StArmed;
                end else begin
                    dly_d = dly_q - DLY_W'(1);
                end
            end
            StArmed: begin
                if (react_press) begin
                    result_d = bus.timer_bcd;
                    if (bus.timer_bcd < best_q) best_d = bus.timer_bcd;
                    round_d  = round_inc;
                    state_d  = last_round ? StEnd : StDone;
                end else if (bus.timer_bcd == Bcd9999) begin
                    result_d = Bcd9999;
                    round_d  = round_inc;
                    state_d  = last_round ? StEnd : StTimeout;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_10k) begin
        if (reset) begin
            state_q      <= StIdle;
            lfsr_q       <= 16'hACE1;
            dly_q        <= '0;
            result_q     <= 16'h0000;
            best_q       <= Bcd9999;
            round_q      <= 4'd0;
            clr_q        <= 1'b0;
            start_prev_q <= 1'b0;
            react_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= {lfsr_q[14:0], lfsr_fb};
            dly_q        <= dly_d;
            result_q     <= result_d;
            best_q       <= best_d;
            round_q      <= round_d;
            clr_q        <= clr_d;
            start_prev_q <= start_lvl;
            react_prev_q <= react_lvl;
        end
    end

    assign bus.cnt_en     = (state_q == StArmed);
    assign bus.led_go     = (state_q == StArmed);
    assign bus.cnt_clr    = clr_q;
    assign bus.result_bcd = result_q;
    assign bus.best_bcd   = best_q;
    assign bus.round_idx  = round_q;
    assign bus.flag       = state_q;
endmodule

// File: tb/tb_reaction_round_ctrl.sv
// Scoreboard bench for reaction_round_ctrl: stimulus queues expected snapshots, monitor checks
// them on every state change and on reset release.
module tb_reaction_round_ctrl;
    localparam int          Rounds   = 3;
    localparam int          MinDly   = 1000;
    localparam logic [15:0] RandMask = 16'h00FF;
    localparam int          Dbnc     = 100;
`ifdef BTN_DEBOUNCE_EN
    localparam int Lat  = 2 + Dbnc;
`else
    localparam int Lat  = 2;
`endif
    localparam int Hold = Lat + 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   t_wait = 0;
    int   t_armed = 0;

    reaction_round_if bus ();

    reaction_round_ctrl #(
        .ROUNDS     (Rounds),
        .MIN_DELAY  (MinDly),
        .RAND_MASK  (RandMask),
        .DLY_W      (15),
        .DBNC_CYCLES(Dbnc)
    ) dut (
        .clk_10k(clk),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [2:0]  flag;
        logic [15:0] result;
        logic [15:0] best;
        logic [3:0]  idx;
        logic        en;
        logic        go;
        logic        clr;
    } snap_t;

    snap_t exp_q[$];

    task automatic expect_snap(input logic [2:0] f, input logic [15:0] res, input logic [15:0] best,
                               input logic [3:0] idx, input logic en, input logic go,
                               input logic clr);
        snap_t s;
        s.flag = f; s.result = res; s.best = best; s.idx = idx; s.en = en; s.go = go; s.clr = clr;
        exp_q.push_back(s);
    endtask

    // Monitor: the DUT presents an output whenever flag changes or right after reset releases.
    initial begin
        logic [2:0] last_flag;
        logic       last_rst;
        snap_t      act, e;
        last_flag = 3'd0;
        last_rst  = 1'b1;
        forever begin
            @(negedge clk);
            if (!reset && (last_rst || bus.flag !== last_flag)) begin
                act = {bus.flag, bus.result_bcd, bus.best_bcd, bus.round_idx, bus.cnt_en,
                       bus.led_go, bus.cnt_clr};
                if (bus.flag == 3'd1) t_wait = cyc;
                if (bus.flag == 3'd2) t_armed = cyc;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output at cyc %0d: got %h, nothing expected",
                             cyc, act);
                end else begin
                    e = exp_q.pop_front();
                    if (act !== e) begin
                        errors++;
                        $display("FAIL snapshot cyc %0d: flag/res/best/idx/en/go/clr got %0d/%h/%h/%0d/%b/%b/%b want %0d/%h/%h/%0d/%b/%b/%b",
                                 cyc, act.flag, act.result, act.best, act.idx, act.en, act.go,
                                 act.clr, e.flag, e.result, e.best, e.idx, e.en, e.go, e.clr);
                    end
                end
            end
            last_flag = bus.flag;
            last_rst  = reset;
        end
    end

    task automatic wait_flag(input logic [2:0] f);
        int n;
        n = 0;
        while (bus.flag !== f && n < 5000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.flag !== f) begin
            errors++;
            $display("FAIL wait_flag: flag %0d, required %0d within 5000 cycles", bus.flag, f);
        end
    endtask

    task automatic check_holdoff();
        int d;
        #1;
        d = t_armed - t_wait;
        checks++;
        if (d < MinDly + 1 || d > MinDly + int'(RandMask) + 1) begin
            errors++;
            $display("FAIL holdoff: %0d cycles, required %0d..%0d", d, MinDly + 1,
                     MinDly + int'(RandMask) + 1);
        end
    endtask

    task automatic press(input logic u, input logic d);
        @(posedge clk); #1;
        bus.BTNU = u;
        bus.BTND = d;
        repeat (Hold) @(posedge clk);
        #1;
        bus.BTNU = 1'b0;
        bus.BTND = 1'b0;
        repeat (Hold) @(posedge clk);
    endtask

    task automatic timed_round(input logic [15:0] t, input logic [2:0] end_flag);
        press(1'b1, 1'b0);
        wait_flag(3'd2);
        check_holdoff();
        bus.timer_bcd = t;
        press(1'b0, 1'b1);
        wait_flag(end_flag);
        bus.timer_bcd = 16'h0000;
    endtask

    initial begin
        bus.BTNU = 1'b0;
        bus.BTND = 1'b0;
        bus.timer_bcd = 16'h0000;
        expect_snap(3'd0, 16'h0000, 16'h9999, 4'd0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (5) @(posedge clk);

        // Session 1: good reaction, false start, timeout ending the session.
        expect_snap(3'd1, 16'h0000, 16'h9999, 4'd0, 1'b0, 1'b0, 1'b1);
        expect_snap(3'd2, 16'h0000, 16'h9999, 4'd0, 1'b1, 1'b1, 1'b0);
        expect_snap(3'd3, 16'h0234, 16'h0234, 4'd1, 1'b0, 1'b0, 1'b0);
        timed_round(16'h0234, 3'd3);

        expect_snap(3'd1, 16'h0234, 16'h0234, 4'd1, 1'b0, 1'b0, 1'b1);
        expect_snap(3'd4, 16'h9999, 16'h0234, 4'd2, 1'b0, 1'b0, 1'b0);
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        wait_flag(3'd4);

        expect_snap(3'd1, 16'h9999, 16'h0234, 4'd2, 1'b0, 1'b0, 1'b1);
        expect_snap(3'd2, 16'h9999, 16'h0234, 4'd2, 1'b1, 1'b1, 1'b0);
        expect_snap(3'd6, 16'h9999, 16'h0234, 4'd3, 1'b0, 1'b0, 1'b0);
        press(1'b1, 1'b0);
        wait_flag(3'd2);
        bus.timer_bcd = 16'h9999;
        wait_flag(3'd6);
        bus.timer_bcd = 16'h0000;

        // Session 2: plain timeout, press coinciding with 9999, simultaneous buttons.
        expect_snap(3'd1, 16'h9999, 16'h9999, 4'd0, 1'b0, 1'b0, 1'b1);
        expect_snap(3'd2, 16'h9999, 16'h9999, 4'd0, 1'b1, 1'b1, 1'b0);
        expect_snap(3'd5, 16'h9999, 16'h9999, 4'd1, 1'b0, 1'b0, 1'b0);
        press(1'b1, 1'b0);
        wait_flag(3'd2);
        bus.timer_bcd = 16'h9999;
        wait_flag(3'd5);
        bus.timer_bcd = 16'h0000;

        expect_snap(3'd1, 16'h9999, 16'h9999, 4'd1, 1'b0, 1'b0, 1'b1);
        expect_snap(3'd2, 16'h9999, 16'h9999, 4'd1, 1'b1, 1'b1, 1'b0);
        expect_snap(3'd3, 16'h9999, 16'h9999, 4'd2, 1'b0, 1'b0, 1'b0);
        press(1'b1, 1'b0);
        wait_flag(3'd2);
        @(posedge clk); #1;
        bus.BTND = 1'b1;
        repeat (Lat) @(posedge clk);
        #1 bus.timer_bcd = 16'h9999;
        wait_flag(3'd3);
        @(posedge clk); #1;
        bus.BTND = 1'b0;
        bus.timer_bcd = 16'h0000;
        repeat (Hold) @(posedge clk);

        expect_snap(3'd1, 16'h9999, 16'h9999, 4'd2, 1'b0, 1'b0, 1'b1);
        expect_snap(3'd6, 16'h9999, 16'h9999, 4'd3, 1'b0, 1'b0, 1'b0);
        press(1'b1, 1'b1);
        wait_flag(3'd1);
        press(1'b1, 1'b1);
        wait_flag(3'd6);

        // Session 3: three timed rounds, best is the minimum.
        expect_snap(3'd1, 16'h9999, 16'h9999, 4'd0, 1'b0, 1'b0, 1'b1);
        expect_snap(3'd2, 16'h9999, 16'h9999, 4'd0, 1'b1, 1'b1, 1'b0);
        expect_snap(3'd3, 16'h0300, 16'h0300, 4'd1, 1'b0, 1'b0, 1'b0);
        timed_round(16'h0300, 3'd3);
        expect_snap(3'd1, 16'h0300, 16'h0300, 4'd1, 1'b0, 1'b0, 1'b1);
        expect_snap(3'd2, 16'h0300, 16'h0300, 4'd1, 1'b1, 1'b1, 1'b0);
        expect_snap(3'd3, 16'h0250, 16'h0250, 4'd2, 1'b0, 1'b0, 1'b0);
        timed_round(16'h0250, 3'd3);
        expect_snap(3'd1, 16'h0250, 16'h0250, 4'd2, 1'b0, 1'b0, 1'b1);
        expect_snap(3'd2, 16'h0250, 16'h0250, 4'd2, 1'b1, 1'b1, 1'b0);
        expect_snap(3'd6, 16'h0410, 16'h0250, 4'd3, 1'b0, 1'b0, 1'b0);
        timed_round(16'h0410, 3'd6);

        // Restart from END, then reset while ARMED.
        expect_snap(3'd1, 16'h0410, 16'h9999, 4'd0, 1'b0, 1'b0, 1'b1);
        expect_snap(3'd2, 16'h0410, 16'h9999, 4'd0, 1'b1, 1'b1, 1'b0);
        press(1'b1, 1'b0);
        wait_flag(3'd2);
`ifdef BTN_DEBOUNCE_EN
        @(posedge clk); #1;
        bus.BTND = 1'b1;
        repeat (50) @(posedge clk);
        #1 bus.BTND = 1'b0;
        repeat (150) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.flag !== 3'd2) begin
            errors++;
            $display("FAIL glitch_filtered: flag %0d, required 2", bus.flag);
        end
`endif
        expect_snap(3'd0, 16'h0000, 16'h9999, 4'd0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expectations: %0d pending, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
